// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the fetch stage.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] instr_t;

  // addi x0, x0, 0 -- canonical bubble injected into decode
  localparam instr_t NOP_INSTR        = 32'h0000_0013;
  localparam addr_t  RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : riscv_pkg

// File: rtl/fetch_stage_if.sv
// Hazard-control, instruction-memory and decode-side signals of the fetch stage.
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic                  StallF;
  logic                  StallD;
  logic                  FlushD;
  logic                  PCSrcE;
  logic [DATA_WIDTH-1:0] PCTargetE;
  logic [DATA_WIDTH-1:0] InstrF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] InstrD;
  logic [DATA_WIDTH-1:0] PCD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic                  ValidD;
  logic [CNT_WIDTH-1:0]  StallCount;
  logic [CNT_WIDTH-1:0]  FlushCount;

  // Fetch stage side: drives the fetch address and the decode register.
  modport master (
    input  StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, StallCount, FlushCount
  );

  // Environment side: hazard unit, execute stage, instruction memory, decode.
  modport slave (
    output StallF, StallD, FlushD, PCSrcE, PCTargetE, InstrF,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, StallCount, FlushCount
  );

endinterface : fetch_stage_if

// File: rtl/pipe_reg.sv
// Generic pipeline register: sync reset > clear > enable, both forcing CLR_VALUE.
module pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= CLR_VALUE;
    end else if (clr) begin
      q <= CLR_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule : pipe_reg

// File: rtl/fetch_stage.sv
// RV32I fetch stage: program counter, IF/ID pipeline register and
// saturating stall/flush event counters.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{
    instr:    DATA_WIDTH'(NOP_INSTR),
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 hit);
    return (hit && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  pc_en;
  ifid_t                 ifid_d;
  ifid_t                 ifid_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_d;
  logic [CNT_WIDTH-1:0]  flush_cnt_q;
  logic [CNT_WIDTH-1:0]  flush_cnt_d;

  // Wraps modulo 2^DATA_WIDTH by construction.
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);

  // A redirect must win over StallF, otherwise a load-use stall that lines
  // up with a taken branch would drop the branch target.
  assign pc_d  = bus.PCSrcE ? bus.PCTargetE : pc_plus4;
  assign pc_en = bus.PCSrcE || !bus.StallF;

  pipe_reg #(
    .WIDTH     (DATA_WIDTH),
    .CLR_VALUE (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc_q)
  );

  assign ifid_d = '{
    instr:    bus.InstrF,
    pc:       pc_q,
    pc_plus4: pc_plus4,
    valid:    1'b1
  };

  // Flush (clr) has priority over stall (en low), so FlushD+StallD yields a bubble.
  pipe_reg #(
    .WIDTH     ($bits(ifid_t)),
    .CLR_VALUE (IFID_BUBBLE)
  ) u_ifid_reg (
    .clk (clk),
    .rst (rst),
    .clr (bus.FlushD),
    .en  (!bus.StallD),
    .d   (ifid_d),
    .q   (ifid_q)
  );

  // NOTE: every always_comb output gets its default on the first line, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = sat_inc(stall_cnt_q, bus.StallD && !bus.FlushD);
    flush_cnt_d = sat_inc(flush_cnt_q, bus.FlushD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.PCF        = pc_q;
  assign bus.InstrD     = ifid_q.instr;
  assign bus.PCD        = ifid_q.pc;
  assign bus.PCPlus4D   = ifid_q.pc_plus4;
  assign bus.ValidD     = ifid_q.valid;
  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with a queue-based scoreboard; a second
// instance with 2-bit counters exercises counter saturation.
module tb_fetch_stage;

  typedef struct {
    logic        rst;
    logic        sf;
    logic        sd;
    logic        fd;
    logic        ps;
    logic [31:0] tgt;
    logic [31:0] pcf;
    logic [31:0] pcd;
    logic        v;
    int          s;
    int          f;
    int          ss;
    int          sfl;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  // Instruction ROM: each word is tagged with its own address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  fetch_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();
  fetch_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(2))  sat_bus ();

  fetch_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0),
    .CNT_WIDTH  (16)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_stage #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0),
    .CNT_WIDTH  (2)
  ) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sat_bus)
  );

  assign bus.InstrF        = rom(bus.PCF);
  assign sat_bus.InstrF    = rom(sat_bus.PCF);
  assign sat_bus.StallF    = bus.StallF;
  assign sat_bus.StallD    = bus.StallD;
  assign sat_bus.FlushD    = bus.FlushD;
  assign sat_bus.PCSrcE    = bus.PCSrcE;
  assign sat_bus.PCTargetE = bus.PCTargetE;

  function automatic vec_t mk(input logic rst_v, sf, sd, fd, ps,
                              input logic [31:0] tgt, pcf, pcd,
                              input logic v, input int s, f, ss, sfl);
    vec_t r;
    r.rst = rst_v; r.sf = sf; r.sd = sd; r.fd = fd; r.ps = ps; r.tgt = tgt;
    r.pcf = pcf; r.pcd = pcd; r.v = v; r.s = s; r.f = f; r.ss = ss; r.sfl = sfl;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_miss++;
      $display("FAIL vec%0d %s: got %h expected %h", n_vec, name, act, req);
    end
  endtask

  // Scoreboard monitor: one expected entry per clock edge, sampled 1 time unit after it.
  initial begin
    vec_t        e;
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e       = exp_q.pop_front();
        e_instr = e.v ? rom(e.pcd) : 32'h0000_0013;
        e_p4    = e.v ? e.pcd + 32'd4 : 32'h0;
        check("PCF",        bus.PCF,                e.pcf);
        check("InstrD",     bus.InstrD,             e_instr);
        check("PCD",        bus.PCD,                e.pcd);
        check("PCPlus4D",   bus.PCPlus4D,           e_p4);
        check("ValidD",     32'(bus.ValidD),        32'(e.v));
        check("StallCount", 32'(bus.StallCount),    32'(e.s));
        check("FlushCount", 32'(bus.FlushCount),    32'(e.f));
        check("SatStall",   32'(sat_bus.StallCount), 32'(e.ss));
        check("SatFlush",   32'(sat_bus.FlushCount), 32'(e.sfl));
        n_vec++;
      end
    end
  end

  initial begin
    //                 rst sf sd fd ps tgt            pcf            pcd            v  s  f ss sf
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 0, 0, 0));
    // free run
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h4,         32'h0,         1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h8,         32'h4,         1, 0, 0, 0, 0));
    // stall F+D at PCF=8
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h8,         32'h4,         1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h8,         32'h4,         1, 2, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'hC,         32'h8,         1, 2, 0, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h10,        32'hC,         1, 2, 0, 2, 0));
    // redirect to 0x100 with flush at PCF=16
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h100,       32'h100,       32'h0,         0, 2, 1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h104,       32'h100,       1, 2, 1, 2, 1));
    // redirect beats StallF; flush beats StallD
    vecs.push_back(mk(0, 1, 1, 1, 1, 32'h40,        32'h40,        32'h0,         0, 2, 2, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h44,        32'h40,        1, 2, 2, 2, 2));
    // duplicate fetch: StallF without StallD
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,         32'h44,        32'h44,        1, 2, 2, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h48,        32'h44,        1, 2, 2, 2, 2));
    // PC wrap
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h48,        1, 2, 2, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 1, 2, 2, 2, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h4,         32'h0,         1, 2, 2, 2, 2));
    // five stall cycles: 2-bit counter saturates at 3
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h4,         32'h0,         1, 3, 2, 3, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h4,         32'h0,         1, 4, 2, 3, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h4,         32'h0,         1, 5, 2, 3, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h4,         32'h0,         1, 6, 2, 3, 2));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h4,         32'h0,         1, 7, 2, 3, 2));
    // flush alone: PC advances, decode bubbled, flush counter saturates
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,         32'h8,         32'h0,         0, 7, 3, 3, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 32'h0,         32'hC,         32'h0,         0, 7, 4, 3, 3));
    // reset in the middle of a stall
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'hC,         32'h0,         0, 8, 4, 3, 3));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,         32'h0,         32'h0,         0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 32'h0,         32'h0,         32'h0,         0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,         32'h4,         32'h0,         1, 1, 0, 1, 0));

    rst           = 1'b1;
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.PCSrcE    = 1'b0;
    bus.PCTargetE = 32'h0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      bus.StallF    = vecs[i].sf;
      bus.StallD    = vecs[i].sd;
      bus.FlushD    = vecs[i].fd;
      bus.PCSrcE    = vecs[i].ps;
      bus.PCTargetE = vecs[i].tgt;
      exp_q.push_back(vecs[i]);
    end

    @(negedge clk);
    rst        = 1'b0;
    bus.StallF = 1'b0;
    bus.StallD = 1'b0;
    bus.FlushD = 1'b0;
    bus.PCSrcE = 1'b0;

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_fetch_stage
